// File: rtl/im_loader.sv
// im_loader: boot loader that parses a framed byte stream into 32-bit words for
// the instruction memory, then releases the CPU's reset once the checksum verifies.
`default_nettype none

module im_loader #(
  parameter int ADDR_BITS = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 im_we,
  output logic [ADDR_BITS-1:0] im_addr,
  output logic [31:0]          im_wdata,
  output logic                 cpu_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CHK    = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_BITS;

  state_t               state_q;
  logic [15:0]          len_q;
  logic [7:0]           sum_q;
  logic [1:0]           bcnt_q;
  logic [ADDR_BITS:0]   wcnt_q;
  logic [23:0]          asm_q;
  logic                 im_we_q;
  logic [ADDR_BITS-1:0] im_addr_q;
  logic [31:0]          im_wdata_q;
  logic                 cpu_rst_q;

  logic                 accept;
  logic [7:0]           sum_d;
  logic [15:0]          len_d;
  logic [ADDR_BITS:0]   wcnt_d;

  assign in_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                    (state_q == S_DATA)   || (state_q == S_CHK);
  assign busy     = (state_q == S_LEN_HI) || (state_q == S_DATA) || (state_q == S_CHK);
  assign done     = (state_q == S_DONE);
  assign error    = (state_q == S_ERR);
  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign cpu_rst  = cpu_rst_q;

  assign accept = in_valid & in_ready;
  assign sum_d  = sum_q + in_data;
  assign len_d  = {in_data, len_q[7:0]};
  assign wcnt_d = wcnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_LEN_LO;
      len_q      <= '0;
      sum_q      <= '0;
      bcnt_q     <= '0;
      wcnt_q     <= '0;
      asm_q      <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      cpu_rst_q  <= 1'b0;
    end else begin
      im_we_q <= 1'b0;
      if (state_q == S_DONE) cpu_rst_q <= 1'b1;
      if (accept) begin
        case (state_q)
          S_LEN_LO: begin
            len_q[7:0] <= in_data;
            sum_q      <= sum_d;
            state_q    <= S_LEN_HI;
          end
          S_LEN_HI: begin
            len_q[15:8] <= in_data;
            sum_q       <= sum_d;
            if ({1'b0, len_d} > MAX_WORDS) state_q <= S_ERR;
            else if (len_d == 16'd0)       state_q <= S_CHK;
            else                           state_q <= S_DATA;
          end
          S_DATA: begin
            sum_q  <= sum_d;
            bcnt_q <= bcnt_q + 2'd1;
            // Little-endian assembly: older bytes drift toward bit 0.
            asm_q  <= {in_data, asm_q[23:8]};
            if (bcnt_q == 2'd3) begin
              im_we_q    <= 1'b1;
              im_addr_q  <= wcnt_q[ADDR_BITS-1:0];
              im_wdata_q <= {in_data, asm_q};
              wcnt_q     <= wcnt_d;
              if (17'(wcnt_d) == {1'b0, len_q}) state_q <= S_CHK;
            end
          end
          S_CHK: begin
            if (sum_d == 8'd0) state_q <= S_DONE;
            else               state_q <= S_ERR;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/im_loader.md
# im_loader

Boot-time program loader that sits directly upstream of the single-cycle CPU's instruction memory. It receives a framed byte stream over a valid/ready interface and assembles little-endian 32-bit instruction words. Each word is written sequentially into instruction memory from address 0. After the frame checksum verifies, it releases the CPU's active-low reset, so the CPU starts fetching a freshly loaded program instead of relying only on the memory init file.

## Interface
- `ADDR_BITS`, 11: instruction-memory word-address width; capacity is 2^ADDR_BITS words (2048).
- `clk` input 1: single clock, shared with the CPU.
- `rst` input 1: asynchronous, active-low reset.
- `in_valid` input 1: byte-stream valid.
- `in_data` input 8: byte-stream data.
- `in_ready` output 1: loader can accept a byte.
- `im_we` output 1: one-cycle instruction-memory write strobe.
- `im_addr` output ADDR_BITS: instruction-memory word address.
- `im_wdata` output 32: instruction word to write.
- `cpu_rst` output 1: active-low reset to the CPU; held 0 until the load succeeds.
- `busy` output 1: load in progress.
- `done` output 1: load completed and checksum good; sticky.
- `error` output 1: length or checksum failure; sticky.

## Operation
- Frame format: LEN_LO, LEN_HI, then N×4 data bytes, then one CHK byte.
  - N = {LEN_HI, LEN_LO}, unsigned word count.
  - Data words are little-endian: the first byte is bits [7:0].
- Byte acceptance: a byte is accepted only in a cycle where `in_valid & in_ready`. The loader ignores `in_data` in all other cycles.
- FSM states: S_LEN_LO → S_LEN_HI → S_DATA → S_CHK → S_DONE / S_ERR.
  - S_LEN_LO: accept a byte and latch it into len[7:0]; go to S_LEN_HI.
  - S_LEN_HI: accept a byte and latch len[15:8].
    - If the full N > 2^ADDR_BITS, go to S_ERR.
    - Else if N == 0, go to S_CHK.
    - Else go to S_DATA.
  - S_DATA: accept bytes into a 2-bit byte counter and a 32-bit shift/assembly register.
    - On the 4th byte, register `im_wdata` = the assembled word and `im_addr` = word counter, and pulse `im_we`.
    - Then increment the word counter.
    - After word N-1 is accepted, go to S_CHK.
  - S_CHK: accept the CHK byte.
    - If (running sum + CHK) mod 256 == 0x00, go to S_DONE; else go to S_ERR.
  - S_DONE and S_ERR are terminal. Only `rst` exits them.
- Checksum: an 8-bit modulo-256 running sum of every accepted byte from LEN_LO through the last data byte. CHK is not included in the running sum.
- `in_ready` = 1 in S_LEN_LO, S_LEN_HI, S_DATA and S_CHK; 0 in S_DONE and S_ERR. It is decoded combinationally from the state register only, with no dependency on `in_valid`.
- `busy` = 1 in S_LEN_HI, S_DATA and S_CHK, and also in S_LEN_LO once the first byte has been accepted. It equals `in_ready` except before the first byte.
- `done` = (state == S_DONE). `error` = (state == S_ERR).
- `cpu_rst` is a register: it goes to 1 on the first clock edge on which the state is S_DONE and stays 1. In S_ERR it stays 0.
- Word counter width: ADDR_BITS+1, so that N = 2^ADDR_BITS is legal. The last write address is 2^ADDR_BITS − 1, so `im_addr` never wraps during a legal load.

## Timing
- Reset (`rst` = 0, asynchronous) forces:
  - state = S_LEN_LO;
  - `im_we`=0, `im_addr`=0, `im_wdata`=0;
  - `cpu_rst`=0, `busy`=0, `done`=0, `error`=0;
  - the sum, byte counter and word counter to 0.
  - `in_ready` is therefore 1 during reset.
- Reset mid-load: the load is abandoned immediately and any partial word is discarded. Words already written stay in instruction memory; they are overwritten by the next load.
- Write latency: `im_we`, `im_addr` and `im_wdata` are valid in the cycle after the clock edge that accepts the 4th byte of a word. `im_we` is high for exactly one cycle.
- Throughput: one byte per cycle with no bubbles. Back-to-back words produce `im_we` pulses every 4 cycles.
- Completion: the CHK byte is accepted at edge k. `done`/`error` are high after edge k. `cpu_rst` is high after edge k+1.
- Length error: `error` is high after the edge that accepts LEN_HI, and `in_ready` is 0 from then on.
- Gaps: `in_valid` may drop at any byte boundary. State and counters hold while no byte is accepted.

## Test plan
- Good 1-word load: send 01 00 05 00 01 20 D9.
  - Required: a single `im_we` pulse with addr 0 and data 0x20010005.
  - `done`=1 one cycle after CHK; `cpu_rst`=1 one cycle after that; `error`=0; `in_ready`=0 afterwards.
- Empty frame: send 00 00 00.
  - Required: no `im_we`; `done`=1; `cpu_rst` rises.
- Bad checksum: send the same frame as the good 1-word load but with CHK = DA.
  - Required: the write to addr 0 still occurs; `error`=1; `cpu_rst` stays 0 for 100 cycles; further `in_valid` bytes are not accepted.
- Oversize length (ADDR_BITS=11): send 01 08.
  - Required: `error`=1 right after LEN_HI; no `im_we` ever.
- Full capacity with throttling: N=0x0800 (2048 words), word i = i, with `in_valid` randomly deasserted about 30% of cycles.
  - Required: 2048 writes at addresses 0..0x7FF, in order, with correct data; `done`=1.
- Reset mid-load: assert `rst` after 2 data bytes of word 1 of a 3-word frame.
  - Required: all outputs reach their reset values immediately; a subsequent complete good frame loads correctly from addr 0.
